// File: rtl/apb_event_ctrl.sv
// apb_event_ctrl: APB slave collecting irq/event lines into pending registers, with a sleep/wake FSM gating core fetch.
// Define EVENT_CTRL_LEVEL_EN to add IRQ_MODE (0x20), which selects level-sensitive irq lines.
module apb_event_ctrl #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NB_LINES       = 32
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NB_LINES-1:0]       irq_i,
    input  logic [NB_LINES-1:0]       event_i,
    output logic                      fetch_enable_o,
    output logic                      irq_o
);
    localparam logic [3:0] IDX_IRQ_EN   = 4'd0;
    localparam logic [3:0] IDX_IRQ_PEND = 4'd1;
    localparam logic [3:0] IDX_IRQ_ACK  = 4'd2;
    localparam logic [3:0] IDX_EVT_EN   = 4'd3;
    localparam logic [3:0] IDX_EVT_PEND = 4'd4;
    localparam logic [3:0] IDX_EVT_ACK  = 4'd5;
    localparam logic [3:0] IDX_SLP_CTRL = 4'd6;
    localparam logic [3:0] IDX_SLP_STAT = 4'd7;
    localparam logic [3:0] IDX_IRQ_MODE = 4'd8;

    typedef enum logic {ST_RUN, ST_SLEEP} state_t;
    state_t state_q, state_d;

    logic [NB_LINES-1:0] irq_en_q, irq_en_d, irq_pend_q, irq_pend_d;
    logic [NB_LINES-1:0] evt_en_q, evt_en_d, evt_pend_q, evt_pend_d;
    logic [NB_LINES-1:0] irq_in_q, evt_in_q, irq_set, evt_set, wdata;
    logic                sleep_req_q, sleep_req_d, irq_o_q, irq_o_d, wake;
    logic [3:0]          idx;
    logic                access, unmapped, slverr, wr_en, wr_sleep;
    logic                unused_bits;

    function automatic logic [31:0] zext(input logic [NB_LINES-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NB_LINES-1:0] = v;
        return r;
    endfunction

    assign idx     = PADDR[5:2];
    assign access  = PSEL & PENABLE;
`ifdef EVENT_CTRL_LEVEL_EN
    assign unmapped = (idx > IDX_IRQ_MODE);
`else
    assign unmapped = idx[3];
`endif
    assign slverr   = access & (unmapped | (PWRITE & (idx == IDX_SLP_STAT)));
    assign wr_en    = access & PWRITE & ~slverr;
    assign wr_sleep = wr_en & (idx == IDX_SLP_CTRL);
    assign wdata    = PWDATA[NB_LINES-1:0];
    assign unused_bits = ^{PADDR, PWDATA};

    assign PSLVERR = slverr;
    assign PREADY  = 1'b1;

`ifdef EVENT_CTRL_LEVEL_EN
    logic [NB_LINES-1:0] irq_mode_q, irq_mode_d;
    assign irq_mode_d = (wr_en && idx == IDX_IRQ_MODE) ? wdata : irq_mode_q;
    assign irq_set    = (irq_i & ~irq_in_q) | (irq_i & irq_mode_q);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) irq_mode_q <= '0;
        else          irq_mode_q <= irq_mode_d;
    end
`else
    assign irq_set = irq_i & ~irq_in_q;
`endif
    assign evt_set = event_i & ~evt_in_q;

    // Clear is applied before set so a simultaneous rise or write-1-set always survives an ack.
    assign irq_en_d   = (wr_en && idx == IDX_IRQ_EN) ? wdata : irq_en_q;
    assign evt_en_d   = (wr_en && idx == IDX_EVT_EN) ? wdata : evt_en_q;
    assign irq_pend_d = (irq_pend_q & ~((wr_en && idx == IDX_IRQ_ACK) ? wdata : '0))
                      | irq_set | ((wr_en && idx == IDX_IRQ_PEND) ? wdata : '0);
    assign evt_pend_d = (evt_pend_q & ~((wr_en && idx == IDX_EVT_ACK) ? wdata : '0))
                      | evt_set | ((wr_en && idx == IDX_EVT_PEND) ? wdata : '0);
    assign irq_o_d    = |(irq_pend_d & irq_en_d);
    assign wake       = (|(evt_pend_q & evt_en_q)) | (|(irq_pend_q & irq_en_q));

    always_comb begin
        state_d        = state_q;
        sleep_req_d    = sleep_req_q;
        fetch_enable_o = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (wr_sleep) begin
                    if (PWDATA[0] && !wake) begin
                        state_d     = ST_SLEEP;
                        sleep_req_d = 1'b1;
                    end else begin
                        sleep_req_d = 1'b0;
                    end
                end
            end
            ST_SLEEP: begin
                fetch_enable_o = 1'b0;
                if (wake || (wr_sleep && !PWDATA[0])) begin
                    state_d     = ST_RUN;
                    sleep_req_d = 1'b0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_RUN;
            sleep_req_q <= 1'b0;
            irq_en_q    <= '0;
            irq_pend_q  <= '0;
            evt_en_q    <= '0;
            evt_pend_q  <= '0;
            irq_in_q    <= '0;
            evt_in_q    <= '0;
            irq_o_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sleep_req_q <= sleep_req_d;
            irq_en_q    <= irq_en_d;
            irq_pend_q  <= irq_pend_d;
            evt_en_q    <= evt_en_d;
            evt_pend_q  <= evt_pend_d;
            irq_in_q    <= irq_i;
            evt_in_q    <= event_i;
            irq_o_q     <= irq_o_d;
        end
    end

    assign irq_o = irq_o_q;

    always_comb begin
        PRDATA = '0;
        if (access && !PWRITE) begin
            case (idx)
                IDX_IRQ_EN:   PRDATA = zext(irq_en_q);
                IDX_IRQ_PEND: PRDATA = zext(irq_pend_q);
                IDX_EVT_EN:   PRDATA = zext(evt_en_q);
                IDX_EVT_PEND: PRDATA = zext(evt_pend_q);
                IDX_SLP_CTRL: PRDATA = {31'b0, sleep_req_q};
                IDX_SLP_STAT: PRDATA = {31'b0, (state_q == ST_SLEEP)};
`ifdef EVENT_CTRL_LEVEL_EN
                IDX_IRQ_MODE: PRDATA = zext(irq_mode_q);
`endif
                default:      PRDATA = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_event_ctrl.sv
// Self-checking bench for apb_event_ctrl (NB_LINES = 8): directed scenarios plus randomized traffic vs a reference model.
module tb_apb_event_ctrl;
    localparam int NB = 8;
    localparam int AW = 12;

    logic          HCLK, HRESETn;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA, PRDATA;
    logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [NB-1:0] irq_i, event_i;
    logic          fetch_enable_o, irq_o;

    int total = 0;
    int bad   = 0;

    apb_event_ctrl #(.APB_ADDR_WIDTH(AW), .NB_LINES(NB)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .irq_i(irq_i), .event_i(event_i), .fetch_enable_o(fetch_enable_o), .irq_o(irq_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Reference model: register contents tracked per line from the rules of the register map.
    logic [NB-1:0] m_ie, m_ip, m_ee, m_ep, m_mode, m_iprev, m_eprev;
    logic          m_sreq, m_asleep, m_irqo;
    logic [NB-1:0] n_ie, n_ip, n_ee, n_ep, n_mode, m_wd;
    logic          n_sreq, n_asleep, n_irqo, m_wr, m_wake, m_slp_wr, m_set, m_clr;
    logic [3:0]    m_ix;

`ifdef EVENT_CTRL_LEVEL_EN
    localparam bit LEVEL = 1'b1;
`else
    localparam bit LEVEL = 1'b0;
`endif

    function automatic logic m_err(input logic wr, input logic [3:0] ix);
        int top;
        top = LEVEL ? 8 : 7;
        return (int'(ix) > top) || (wr && ix == 4'd7);
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] ix);
        case (ix)
            4'd0: return 32'(m_ie);
            4'd1: return 32'(m_ip);
            4'd3: return 32'(m_ee);
            4'd4: return 32'(m_ep);
            4'd6: return {31'b0, m_sreq};
            4'd7: return {31'b0, m_asleep};
            4'd8: return LEVEL ? 32'(m_mode) : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        m_ix     = PADDR[5:2];
        m_wd     = PWDATA[NB-1:0];
        m_wr     = PSEL && PENABLE && PWRITE && !m_err(1'b1, PADDR[5:2]);
        m_wake   = ((m_ip & m_ie) != 0) || ((m_ep & m_ee) != 0);
        m_slp_wr = m_wr && m_ix == 4'd6;
        m_set    = 1'b0;
        m_clr    = 1'b0;
        n_ie     = (m_wr && m_ix == 4'd0) ? m_wd : m_ie;
        n_ee     = (m_wr && m_ix == 4'd3) ? m_wd : m_ee;
        n_mode   = (LEVEL && m_wr && m_ix == 4'd8) ? m_wd : m_mode;
        n_ip     = m_ip;
        n_ep     = m_ep;
        for (int i = 0; i < NB; i++) begin
            m_set   = (irq_i[i] && !m_iprev[i]) || (irq_i[i] && m_mode[i]) || (m_wr && m_ix == 4'd1 && m_wd[i]);
            m_clr   = m_wr && m_ix == 4'd2 && m_wd[i];
            n_ip[i] = m_set ? 1'b1 : (m_clr ? 1'b0 : m_ip[i]);
            m_set   = (event_i[i] && !m_eprev[i]) || (m_wr && m_ix == 4'd4 && m_wd[i]);
            m_clr   = m_wr && m_ix == 4'd5 && m_wd[i];
            n_ep[i] = m_set ? 1'b1 : (m_clr ? 1'b0 : m_ep[i]);
        end
        n_irqo   = (n_ip & n_ie) != 0;
        n_asleep = m_asleep;
        n_sreq   = m_sreq;
        if (!m_asleep && m_slp_wr) begin
            n_asleep = PWDATA[0] && !m_wake;
            n_sreq   = PWDATA[0] && !m_wake;
        end
        if (m_asleep && (m_wake || (m_slp_wr && !PWDATA[0]))) begin
            n_asleep = 1'b0;
            n_sreq   = 1'b0;
        end
    end

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_ie <= '0; m_ip <= '0; m_ee <= '0; m_ep <= '0; m_mode <= '0;
            m_iprev <= '0; m_eprev <= '0; m_sreq <= 1'b0; m_asleep <= 1'b0; m_irqo <= 1'b0;
        end else begin
            m_ie <= n_ie; m_ip <= n_ip; m_ee <= n_ee; m_ep <= n_ep; m_mode <= n_mode;
            m_iprev <= irq_i; m_eprev <= event_i; m_sreq <= n_sreq; m_asleep <= n_asleep; m_irqo <= n_irqo;
        end
    end

    task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d, output logic e);
        @(negedge HCLK); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge HCLK); PENABLE = 1'b1; #1; e = PSLVERR;
        @(negedge HCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] d, output logic e);
        @(negedge HCLK); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge HCLK); PENABLE = 1'b1; #1; d = PRDATA; e = PSLVERR;
        @(negedge HCLK); PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        irq_i = '0; event_i = '0;
        repeat (3) @(negedge HCLK);
        total++; if (fetch_enable_o !== 1'b1) begin bad++; $display("FAIL rst_fetch got=%b exp=1", fetch_enable_o); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq_o); end
        HRESETn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apb_read(AW'(i * 4), d, e);
            total++; if (d !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL rst_read[%0d] got=%h/%b exp=0/0", i, d, e); end
        end
        apb_read(12'h024, d, e);
        total++; if (d !== 32'h0 || e !== 1'b1) begin bad++; $display("FAIL err_read_24 got=%h/%b exp=0/1", d, e); end
        apb_read(12'h020, d, e);
        total++; if (e !== !LEVEL) begin bad++; $display("FAIL err_read_20 got=%b exp=%b", e, !LEVEL); end
        total++; if (PREADY !== 1'b1) begin bad++; $display("FAIL pready got=%b exp=1", PREADY); end
    endtask

    task automatic test_irq_basic();
        logic [31:0] d; logic e;
        apb_write(12'h000, 32'h5, e);
        irq_i = 8'h01;
        @(negedge HCLK); irq_i = '0;
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_o_rise got=%b exp=1", irq_o); end
        apb_read(12'h004, d, e);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL irq_pend got=%h exp=1", d); end
        apb_write(12'h008, 32'h1, e);
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_o_ack got=%b exp=0", irq_o); end
        apb_read(12'h004, d, e);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL irq_pend_ack got=%h exp=0", d); end
        apb_read(12'h008, d, e);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL ack_reads0 got=%h exp=0", d); end
    endtask

    task automatic test_ack_collision();
        logic [31:0] d; logic e;
        apb_write(12'h008, 32'hFF, e);
        @(negedge HCLK); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h008; PWDATA = 32'h4;
        @(negedge HCLK); PENABLE = 1'b1; irq_i = 8'h04;
        @(negedge HCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; irq_i = '0;
        apb_read(12'h004, d, e);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL ack_vs_rise got=%h exp=4", d); end
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL ack_vs_rise_irq got=%b exp=1", irq_o); end
        apb_write(12'h004, 32'h2, e);
        apb_read(12'h004, d, e);
        total++; if (d !== 32'h6) begin bad++; $display("FAIL pend_w1s got=%h exp=6", d); end
        apb_write(12'h008, 32'hFF, e);
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL ack_all_irq got=%b exp=0", irq_o); end
    endtask

    task automatic test_sleep_wake();
        logic [31:0] d; logic e;
        apb_write(12'h000, 32'h0, e);
        apb_write(12'h00C, 32'h8, e);
        apb_write(12'h018, 32'h1, e);
        total++; if (fetch_enable_o !== 1'b0) begin bad++; $display("FAIL sleep_fetch got=%b exp=0", fetch_enable_o); end
        apb_read(12'h01C, d, e);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL sleep_status got=%h exp=1", d); end
        apb_read(12'h018, d, e);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL sleep_ctrl got=%h exp=1", d); end
        event_i = 8'h08;
        @(negedge HCLK); event_i = '0;
        total++; if (fetch_enable_o !== 1'b0) begin bad++; $display("FAIL wake_n1 got=%b exp=0", fetch_enable_o); end
        @(negedge HCLK);
        total++; if (fetch_enable_o !== 1'b1) begin bad++; $display("FAIL wake_n2 got=%b exp=1", fetch_enable_o); end
        apb_read(12'h018, d, e);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL wake_ctrl got=%h exp=0", d); end
        apb_read(12'h010, d, e);
        total++; if (d !== 32'h8) begin bad++; $display("FAIL evt_pend got=%h exp=8", d); end
    endtask

    task automatic test_sleep_blocked();
        logic [31:0] d; logic e;
        apb_write(12'h018, 32'h1, e);
        for (int i = 0; i < 3; i++) begin
            total++; if (fetch_enable_o !== 1'b1) begin bad++; $display("FAIL blocked_fetch[%0d] got=%b exp=1", i, fetch_enable_o); end
            @(negedge HCLK);
        end
        apb_read(12'h018, d, e);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL blocked_ctrl got=%h exp=0", d); end
        apb_read(12'h01C, d, e);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL blocked_status got=%h exp=0", d); end
    endtask

    task automatic test_sleep_abort();
        logic [31:0] d; logic e;
        apb_write(12'h014, 32'hFF, e);
        apb_write(12'h018, 32'h1, e);
        total++; if (fetch_enable_o !== 1'b0) begin bad++; $display("FAIL abort_sleep got=%b exp=0", fetch_enable_o); end
        apb_write(12'h018, 32'h0, e);
        total++; if (fetch_enable_o !== 1'b1) begin bad++; $display("FAIL abort_run got=%b exp=1", fetch_enable_o); end
        apb_read(12'h018, d, e);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL abort_ctrl got=%h exp=0", d); end
    endtask

    task automatic test_width_err();
        logic [31:0] d; logic e;
        apb_write(12'h000, 32'hFFFFFFFF, e);
        apb_read(12'h000, d, e);
        total++; if (d !== 32'h000000FF) begin bad++; $display("FAIL width_ie got=%h exp=000000ff", d); end
        apb_write(12'h000, 32'h0, e);
        apb_write(12'h01C, 32'h1, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL err_wr_status got=%b exp=1", e); end
        total++; if (fetch_enable_o !== 1'b1) begin bad++; $display("FAIL err_wr_fetch got=%b exp=1", fetch_enable_o); end
        apb_write(12'h024, 32'hFF, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL err_wr_24 got=%b exp=1", e); end
        apb_read(12'h004, d, e);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL err_wr_noeffect got=%h exp=0", d); end
        apb_write(12'h004, 32'h0, e);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL ok_wr_err got=%b exp=0", e); end
    endtask

    task automatic test_level();
`ifdef EVENT_CTRL_LEVEL_EN
        logic [31:0] d; logic e;
        apb_write(12'h020, 32'h1, e);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL mode_err got=%b exp=0", e); end
        apb_read(12'h020, d, e);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL mode_read got=%h exp=1", d); end
        irq_i = 8'h01;
        apb_write(12'h008, 32'h1, e);
        apb_read(12'h004, d, e);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL level_ack got=%h exp=1", d); end
        irq_i = '0;
        apb_write(12'h008, 32'h1, e);
        apb_read(12'h004, d, e);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL level_low_ack got=%h exp=0", d); end
        apb_write(12'h020, 32'h0, e);
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e;
        apb_write(12'h000, 32'h1, e);
        apb_write(12'h004, 32'h1, e);
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL mid_irq_pre got=%b exp=1", irq_o); end
        #2 HRESETn = 1'b0;
        #1;
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL mid_irq_async got=%b exp=0", irq_o); end
        @(negedge HCLK); HRESETn = 1'b1;
        apb_read(12'h000, d, e);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_ie got=%h exp=0", d); end
        apb_read(12'h004, d, e);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_ip got=%h exp=0", d); end
        apb_write(12'h018, 32'h1, e);
        total++; if (fetch_enable_o !== 1'b0) begin bad++; $display("FAIL mid_sleep got=%b exp=0", fetch_enable_o); end
        #2 HRESETn = 1'b0;
        #1;
        total++; if (fetch_enable_o !== 1'b1) begin bad++; $display("FAIL mid_fetch_async got=%b exp=1", fetch_enable_o); end
        @(negedge HCLK); HRESETn = 1'b1;
        apb_read(12'h01C, d, e);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_status got=%h exp=0", d); end
    endtask

    task automatic test_random();
        logic [3:0] ix;
        logic       exp_err;
        @(negedge HCLK); HRESETn = 1'b0; irq_i = '0; event_i = '0;
        @(negedge HCLK); HRESETn = 1'b1;
        for (int it = 0; it < 300; it++) begin
            @(negedge HCLK);
            total++; if (irq_o !== m_irqo || fetch_enable_o !== !m_asleep) begin
                bad++; $display("FAIL rnd_out[%0d] got=%b%b exp=%b%b", it, irq_o, fetch_enable_o, m_irqo, !m_asleep); end
            irq_i   = NB'($urandom & $urandom & $urandom);
            event_i = NB'($urandom & $urandom & $urandom);
            ix      = 4'($urandom_range(0, 9));
            PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'($urandom_range(0, 1));
            PADDR = AW'({ix, 2'b00}); PWDATA = $urandom & $urandom;
            @(negedge HCLK);
            total++; if (irq_o !== m_irqo || fetch_enable_o !== !m_asleep) begin
                bad++; $display("FAIL rnd_out2[%0d] got=%b%b exp=%b%b", it, irq_o, fetch_enable_o, m_irqo, !m_asleep); end
            irq_i   = NB'($urandom & $urandom);
            event_i = NB'($urandom & $urandom & $urandom);
            PENABLE = 1'b1;
            #1;
            exp_err = m_err(PWRITE, ix);
            total++; if (PSLVERR !== exp_err) begin bad++; $display("FAIL rnd_err[%0d] got=%b exp=%b", it, PSLVERR, exp_err); end
            total++; if (PRDATA !== ((PWRITE || exp_err) ? 32'h0 : m_read(ix))) begin
                bad++; $display("FAIL rnd_rdata[%0d] idx=%0d got=%h exp=%h", it, ix, PRDATA, (PWRITE || exp_err) ? 32'h0 : m_read(ix)); end
        end
        @(negedge HCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; irq_i = '0; event_i = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_irq_basic();
        test_ack_collision();
        test_sleep_wake();
        test_sleep_blocked();
        test_sleep_abort();
        test_width_err();
        test_level();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
